// File: rtl/ternary_k3_word_tx.sv
// Serialises a word of 2-bit ternary trits onto a valid/ready lane, framed
// with start/end markers and an optional mod-3 check trit after the data.
module ternary_k3_word_tx #(
    parameter int unsigned N_TRITS  = 9,
    parameter bit          CHECK_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*N_TRITS-1:0] in_word,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [1:0]           tx_trit,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 tx_sof,
    output logic                 tx_eof,
    output logic                 err_illegal
);

    localparam int unsigned W    = 2 * N_TRITS;
    localparam int unsigned CW   = (N_TRITS > 1) ? $clog2(N_TRITS) : 1;
    localparam int unsigned LAST = N_TRITS - 1;

    localparam logic [1:0] TRIT_ZERO = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    shreg;
    logic [CW-1:0]   cnt;
    logic [1:0]      acc;

    logic [W-1:0]    shreg_sh;
    logic [CW-1:0]   cnt_inc;
    logic [2:0]      acc_sum;
    logic [1:0]      acc_next;
    logic            illegal;

    // Mod-3 weight of a trit: T counts as 2 (i.e. -1), 0 as 0, 1 as 1.
    function automatic logic [1:0] trit_weight(input logic [1:0] t);
        case (t)
            2'b00:   trit_weight = 2'd2;
            2'b10:   trit_weight = 2'd1;
            default: trit_weight = 2'd0;
        endcase
    endfunction

    // Encode the final residue back into a trit code.
    function automatic logic [1:0] check_trit(input logic [1:0] c);
        case (c)
            2'd1:    check_trit = 2'b10;
            2'd2:    check_trit = 2'b00;
            default: check_trit = 2'b01;
        endcase
    endfunction

    assign shreg_sh = shreg >> 2;
    assign cnt_inc  = cnt + CW'(1);
    assign acc_sum  = {1'b0, acc} + {1'b0, trit_weight(tx_trit)};
    assign acc_next = (acc_sum >= 3'd3) ? 2'(acc_sum - 3'd3) : acc_sum[1:0];

    // Flag any trit position carrying the unused code 2'b11.
    always_comb begin
        illegal = 1'b0;
        for (int i = 0; i < int'(N_TRITS); i++) begin
            if (in_word[2*i +: 2] == 2'b11) begin
                illegal = 1'b1;
            end
        end
    end

    // Frame FSM with registered lane outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            acc         <= '0;
            in_ready    <= 1'b1;
            tx_valid    <= 1'b0;
            tx_trit     <= TRIT_ZERO;
            tx_sof      <= 1'b0;
            tx_eof      <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        if (illegal) begin
                            err_illegal <= 1'b1;
                        end else begin
                            state    <= SEND;
                            shreg    <= in_word;
                            cnt      <= '0;
                            acc      <= '0;
                            in_ready <= 1'b0;
                            tx_valid <= 1'b1;
                            tx_trit  <= in_word[1:0];
                            tx_sof   <= 1'b1;
                            tx_eof   <= (N_TRITS == 1) && !CHECK_EN;
                        end
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        acc <= acc_next;
                        if (cnt == CW'(LAST)) begin
                            if (CHECK_EN) begin
                                state   <= CHECK;
                                tx_trit <= check_trit(acc_next);
                                tx_sof  <= 1'b0;
                                tx_eof  <= 1'b1;
                            end else begin
                                state    <= IDLE;
                                in_ready <= 1'b1;
                                tx_valid <= 1'b0;
                                tx_trit  <= TRIT_ZERO;
                                tx_sof   <= 1'b0;
                                tx_eof   <= 1'b0;
                            end
                        end else begin
                            cnt     <= cnt_inc;
                            shreg   <= shreg_sh;
                            tx_trit <= shreg_sh[1:0];
                            tx_sof  <= 1'b0;
                            tx_eof  <= !CHECK_EN && (cnt_inc == CW'(LAST));
                        end
                    end
                end
                CHECK: begin
                    if (tx_ready) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        tx_valid <= 1'b0;
                        tx_trit  <= TRIT_ZERO;
                        tx_sof   <= 1'b0;
                        tx_eof   <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    tx_valid <= 1'b0;
                    tx_trit  <= TRIT_ZERO;
                    tx_sof   <= 1'b0;
                    tx_eof   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ternary_k3_word_tx.sv
// Scoreboard bench for ternary_k3_word_tx: one instance with the check trit,
// one without; expected beats are queued by the stimulus and popped by a monitor.
module tb_ternary_k3_word_tx;

    typedef struct packed {
        logic [1:0] trit;
        logic       sof;
        logic       eof;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [17:0] in_word0, in_word1;
    logic        in_valid0, in_valid1;
    logic        in_ready0, in_ready1;
    logic [1:0]  tx_trit0, tx_trit1;
    logic        tx_valid0, tx_valid1;
    logic        tx_ready0, tx_ready1;
    logic        tx_sof0, tx_sof1;
    logic        tx_eof0, tx_eof1;
    logic        err0, err1;

    int    vectors     = 0;
    int    miscompares = 0;
    beat_t q0[$];
    beat_t q1[$];
    int    hs[2]       = '{0, 0};
    logic  stalled[2]  = '{1'b0, 1'b0};
    beat_t held[2];

    always #5 clk = ~clk;

    ternary_k3_word_tx #(.N_TRITS(9), .CHECK_EN(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_word(in_word0), .in_valid(in_valid0),
        .in_ready(in_ready0), .tx_trit(tx_trit0), .tx_valid(tx_valid0),
        .tx_ready(tx_ready0), .tx_sof(tx_sof0), .tx_eof(tx_eof0),
        .err_illegal(err0)
    );

    ternary_k3_word_tx #(.N_TRITS(9), .CHECK_EN(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_word(in_word1), .in_valid(in_valid1),
        .in_ready(in_ready1), .tx_trit(tx_trit1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .tx_sof(tx_sof1), .tx_eof(tx_eof1),
        .err_illegal(err1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-lane monitor: hold-through-stall, idle lane value, scoreboard pop.
    task automatic mon(input int id, input logic v, input logic r, input beat_t cur);
        beat_t e;
        logic  have;
        have = 1'b0;
        e    = '0;
        if (!rst_n) begin
            stalled[id] = 1'b0;
            return;
        end
        if (stalled[id]) begin
            chk($sformatf("stall_valid%0d", id), 32'(v), 32'd1);
            chk($sformatf("stall_hold%0d", id), 32'(cur), 32'(held[id]));
        end
        if (!v) begin
            chk($sformatf("idle_lane%0d", id), 32'(cur), 32'(4'b0100));
        end
        if (v && r) begin
            if (id == 0) begin
                if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
            end else begin
                if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
            end
            if (!have) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_beat%0d: got %0h expected none at %0t", id, cur, $time);
            end else begin
                chk($sformatf("beat%0d", id), 32'(cur), 32'(e));
            end
            hs[id]++;
        end
        stalled[id] = v && !r;
        held[id]    = cur;
    endtask

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        mon(0, tx_valid0, tx_ready0, {tx_trit0, tx_sof0, tx_eof0});
        mon(1, tx_valid1, tx_ready1, {tx_trit1, tx_sof1, tx_eof1});
    end

    task automatic push_frame(input int id, input logic [1:0] first, input logic [1:0] rest,
                              input logic [1:0] ck, input bit has_check);
        beat_t b;
        for (int i = 0; i < 9; i++) begin
            b.trit = (i == 0) ? first : rest;
            b.sof  = (i == 0);
            b.eof  = !has_check && (i == 8);
            if (id == 0) q0.push_back(b); else q1.push_back(b);
        end
        if (has_check) begin
            b.trit = ck;
            b.sof  = 1'b0;
            b.eof  = 1'b1;
            if (id == 0) q0.push_back(b); else q1.push_back(b);
        end
    endtask

    task automatic offer(input int id, input logic [17:0] w);
        if (id == 0) begin in_word0 = w; in_valid0 = 1'b1; end
        else         begin in_word1 = w; in_valid1 = 1'b1; end
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
    endtask

    task automatic wait_ready(input int id);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if ((id == 0) ? in_ready0 : in_ready1) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("ready_timeout%0d", id), 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  start;
        bit  seen;
        rst_n     = 1'b0;
        in_word0  = '0;
        in_word1  = '0;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        tx_ready0 = 1'b1;
        tx_ready1 = 1'b1;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready0), 32'd1);
        chk("rst_tx_valid", 32'(tx_valid0), 32'd0);
        chk("rst_lane", 32'({tx_trit0, tx_sof0, tx_eof0}), 32'(4'b0100));
        chk("rst_err", 32'(err0), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready(0);

        // Trit0 = 1, rest 0: check trit 1
        push_frame(0, 2'b10, 2'b01, 2'b10, 1'b1);
        offer(0, 18'h15556);
        @(negedge clk);
        chk("latency1_valid", 32'(tx_valid0), 32'd1);
        chk("latency1_sof", 32'(tx_sof0), 32'd1);
        wait_ready(0);

        // All T: check trit 0; in_ready one cycle after eof handshake
        push_frame(0, 2'b00, 2'b00, 2'b01, 1'b1);
        offer(0, 18'h00000);
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (tx_valid0 && tx_eof0 && tx_ready0) begin
                seen = 1'b1;
                chk("eof_in_ready", 32'(in_ready0), 32'd0);
                break;
            end
        end
        chk("eof_seen", 32'(seen), 32'd1);
        @(negedge clk);
        chk("ready_after_eof", 32'(in_ready0), 32'd1);
        chk("valid_after_eof", 32'(tx_valid0), 32'd0);
        @(posedge clk);
        #1;

        // All 1 with alternating tx_ready: every beat stalls once
        push_frame(0, 2'b10, 2'b10, 2'b01, 1'b1);
        start = hs[0];
        offer(0, 18'h2AAAA);
        for (int i = 0; i < 24; i++) begin
            tx_ready0 = (i % 2 == 1);
            @(posedge clk);
            #1;
        end
        tx_ready0 = 1'b1;
        wait_ready(0);
        chk("stall_handshakes", 32'(hs[0] - start), 32'd10);

        // Illegal code in trit 0
        offer(0, 18'h15557);
        @(negedge clk);
        chk("illegal_err", 32'(err0), 32'd1);
        chk("illegal_valid", 32'(tx_valid0), 32'd0);
        chk("illegal_in_ready", 32'(in_ready0), 32'd1);
        @(negedge clk);
        chk("illegal_err_pulse", 32'(err0), 32'd0);
        chk("illegal_valid2", 32'(tx_valid0), 32'd0);
        @(posedge clk);
        #1;

        // Reset mid-frame after beat 4, then a fresh all-zero word
        push_frame(0, 2'b10, 2'b01, 2'b10, 1'b1);
        start = hs[0];
        offer(0, 18'h15556);
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            if (hs[0] >= start + 5) break;
        end
        #1;
        rst_n     = 1'b0;
        tx_ready0 = 1'b0;
        q0.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        tx_ready0 = 1'b1;
        @(negedge clk);
        chk("post_reset_valid", 32'(tx_valid0), 32'd0);
        chk("post_reset_in_ready", 32'(in_ready0), 32'd1);
        chk("post_reset_handshakes", 32'(hs[0] - start), 32'd5);
        push_frame(0, 2'b01, 2'b01, 2'b01, 1'b1);
        start = hs[0];
        offer(0, 18'h15555);
        wait_ready(0);
        chk("zero_word_handshakes", 32'(hs[0] - start), 32'd10);

        // No check trit: nine beats, eof on beat 8
        push_frame(1, 2'b10, 2'b01, 2'b01, 1'b0);
        start = hs[1];
        offer(1, 18'h15556);
        wait_ready(1);
        chk("nocheck_handshakes", 32'(hs[1] - start), 32'd9);

        repeat (3) @(posedge clk);
        #1;
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
